// File: rtl/clock_period_meter.sv
// rtl/clock_period_meter.sv - measures high time and period of a slow input against clk
// Optional watchdog compiled in with CLOCK_PERIOD_METER_TIMEOUT_EN.

module clock_period_meter #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] high_time,
  output logic [WIDTH-1:0] period,
  output logic             timeout
);

  // Elaboration-time sanity checks on the configuration.
  if (WIDTH < 2) begin : g_bad_width
    $error("clock_period_meter: WIDTH must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("clock_period_meter: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_RISE = 3'd1,
    MEAS_HIGH = 3'd2,
    MEAS_LOW  = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  state_t             state_q, state_d;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               prev_q, prev_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   high_time_q, high_time_d;
  logic [WIDTH-1:0]   period_q, period_d;
  logic [WIDTH-1:0]   cnt_inc;
  logic               rise;
  logic               fall;

`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
  logic            measuring;
`endif

  // Edge flags from the synchronized input; both flops share the same latency so
  // every reported difference is unaffected by the pipeline depth.
  always_comb begin
    sync1_d = sig_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise    = sync2_q & ~prev_q;
    fall    = ~sync2_q & prev_q;
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  end

  // Next-state, counter and capture logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    high_time_d = high_time_q;
    period_d    = period_q;
`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
    wd_d        = wd_q;
    timeout_d   = timeout_q;
    measuring   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT_RISE;
`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end
      WAIT_RISE: begin
`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
        measuring = 1'b1;
`endif
        // A fall here belongs to a pulse that started before we were armed.
        if (rise) begin
          cnt_d   = WIDTH'(1);
          state_d = MEAS_HIGH;
        end
      end
      MEAS_HIGH: begin
`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
        measuring = 1'b1;
`endif
        cnt_d = cnt_inc;
        if (fall) begin
          high_time_d = cnt_q;
          state_d     = MEAS_LOW;
        end
      end
      MEAS_LOW: begin
`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
        measuring = 1'b1;
`endif
        cnt_d = cnt_inc;
        if (rise) begin
          period_d = cnt_q;
`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d  = DONE;
        end
      end
      DONE: begin
        // start arriving together with the accept is deliberately dropped.
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
    // Watchdog overrides any capture in the same cycle and aborts the measurement.
    if (measuring) begin
      wd_d = wd_q + 1'b1;
      if (wd_q >= WD_LIMIT) begin
        state_d   = DONE;
        timeout_d = 1'b1;
        period_d  = '0;
        if (state_q != MEAS_LOW) begin
          high_time_d = '0;
        end
      end
    end
`endif
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      prev_q      <= 1'b0;
      cnt_q       <= '0;
      high_time_q <= '0;
      period_q    <= '0;
`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
      wd_q        <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      high_time_q <= high_time_d;
      period_q    <= period_d;
`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
      wd_q        <= wd_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign high_time    = high_time_q;
  assign period       = period_q;
`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
  assign timeout      = timeout_q;
`else
  assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_clock_period_meter.sv
// tb/tb_clock_period_meter.sv - self-checking bench for clock_period_meter

module tb_clock_period_meter;

  localparam int WIDTH = 32;
  localparam int TO    = 100;

  logic             clk = 1'b0;
  logic             rst;
  logic             sig_in;
  logic             start;
  logic             result_ready;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] high_time;
  logic [WIDTH-1:0] period;
  logic             timeout;

  clock_period_meter #(
    .WIDTH          (WIDTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sig_in       (sig_in),
    .start        (start),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .high_time    (high_time),
    .period       (period),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] ht;
    logic [WIDTH-1:0] per;
    logic             to;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   hi_len   = 5;
  int   lo_len   = 5;
  bit   wave_en  = 1'b0;

  // Square-wave generator: sig_in changes on negedges, so it is high for hi_len posedges.
  initial begin : wave_gen
    sig_in = 1'b0;
    forever begin
      if (!wave_en) begin
        sig_in = 1'b0;
        @(negedge clk);
      end else begin
        sig_in = 1'b1;
        repeat (hi_len) @(negedge clk);
        sig_in = 1'b0;
        repeat (lo_len) @(negedge clk);
      end
    end
  end

  task automatic set_wave(input int hi, input int lo);
    wave_en = 1'b0;
    repeat (60) @(negedge clk);
    hi_len  = hi;
    lo_len  = lo;
    wave_en = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic wait_level(input logic v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #1;
      if (sig_in === v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic sync_low();
    bit ok;
    wait_level(1'b1, ok);
    wait_level(1'b0, ok);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_result(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic accept();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    result_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", result_valid); end
    checks++; if (high_time !== '0) begin failures++; $display("FAIL reset_high_time got=%0d want=0", high_time); end
    checks++; if (period !== '0) begin failures++; $display("FAIL reset_period got=%0d want=0", period); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b want=0", timeout); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy got=%b want=0", busy); end
  endtask

  task automatic test_basic();
    bit   ok;
    exp_t e;
    set_wave(5, 5);
    sync_low();
    exp_q.push_back('{ht: 5, per: 10, to: 1'b0});
    pulse_start();
    wait_result(ok);
    checks++;
    if (!ok || exp_q.size() == 0) begin
      failures++; $display("FAIL basic_result_wait got=no_result want=result_valid");
    end else begin
      e = exp_q.pop_front();
      if (high_time !== e.ht) begin failures++; $display("FAIL basic_high_time got=%0d want=%0d", high_time, e.ht); end
      checks++; if (period !== e.per) begin failures++; $display("FAIL basic_period got=%0d want=%0d", period, e.per); end
      checks++; if (timeout !== e.to) begin failures++; $display("FAIL basic_timeout got=%b want=%b", timeout, e.to); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_done got=%b want=1", busy); end
    end
    accept();
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL basic_accept valid=%b busy=%b want=0,0", result_valid, busy);
    end
  endtask

  task automatic test_hold();
    bit   ok;
    int   bad;
    exp_t e;
    set_wave(3, 7);
    sync_low();
    exp_q.push_back('{ht: 3, per: 10, to: 1'b0});
    pulse_start();
    wait_result(ok);
    checks++;
    if (!ok || exp_q.size() == 0) begin
      failures++; $display("FAIL hold_result_wait got=no_result want=result_valid");
    end else begin
      e = exp_q.pop_front();
      if (high_time !== e.ht) begin failures++; $display("FAIL hold_high_time got=%0d want=%0d", high_time, e.ht); end
      checks++; if (period !== e.per) begin failures++; $display("FAIL hold_period got=%0d want=%0d", period, e.per); end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (result_valid !== 1'b1 || high_time !== e.ht || period !== e.per || timeout !== e.to) bad++;
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL hold_stable got=%0d_bad_cycles want=0", bad); end
    end
    accept();
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL hold_accept valid=%b busy=%b want=0,0", result_valid, busy);
    end
  endtask

  task automatic test_start_ignored();
    bit   ok;
    int   phase;
    int   n;
    int   busy_drop;
    exp_t e;
    set_wave(4, 8);
    sync_low();
    exp_q.push_back('{ht: 4, per: 12, to: 1'b0});
    pulse_start();
    ok = 1'b0; phase = 0; n = 0; busy_drop = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #1;
      if (busy !== 1'b1) busy_drop++;
      if (result_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      case (phase)
        0: if (sig_in) phase = 1;
        1: if (!sig_in) phase = 2;
        2: begin
          n++;
          if (n == 5) begin
            pulse_start();
            phase = 3;
          end
        end
        default: ;
      endcase
    end
    checks++; if (busy_drop !== 0) begin failures++; $display("FAIL ignore_busy got=%0d_low_cycles want=0", busy_drop); end
    checks++;
    if (!ok || exp_q.size() == 0) begin
      failures++; $display("FAIL ignore_result_wait got=no_result want=result_valid");
    end else begin
      e = exp_q.pop_front();
      if (high_time !== e.ht || period !== e.per) begin
        failures++; $display("FAIL ignore_result got=%0d/%0d want=%0d/%0d", high_time, period, e.ht, e.per);
      end
    end
    accept();
    repeat (30) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ignore_no_rearm got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid();
    bit   ok;
    int   pulses;
    exp_t e;
    set_wave(20, 20);
    sync_low();
    exp_q.push_back('{ht: 20, per: 40, to: 1'b0});
    pulse_start();
    wait_level(1'b1, ok);
    repeat (8) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    exp_q.delete();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b want=0", result_valid); end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (result_valid !== 1'b0 || busy !== 1'b0) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL rstmid_quiet got=%0d_active_cycles want=0", pulses); end
    checks++;
    if (high_time !== '0 || period !== '0) begin
      failures++; $display("FAIL rstmid_cleared got=%0d/%0d want=0/0", high_time, period);
    end
    set_wave(6, 9);
    sync_low();
    exp_q.push_back('{ht: 6, per: 15, to: 1'b0});
    pulse_start();
    wait_result(ok);
    checks++;
    if (!ok || exp_q.size() == 0) begin
      failures++; $display("FAIL rstmid_fresh_wait got=no_result want=result_valid");
    end else begin
      e = exp_q.pop_front();
      if (high_time !== e.ht || period !== e.per || timeout !== e.to) begin
        failures++; $display("FAIL rstmid_fresh got=%0d/%0d/%b want=%0d/%0d/%b",
                             high_time, period, timeout, e.ht, e.per, e.to);
      end
    end
    accept();
  endtask

  task automatic test_back_to_back();
    bit   ok;
    exp_t e;
    set_wave(1, 1);
    exp_q.push_back('{ht: 1, per: 2, to: 1'b0});
    exp_q.push_back('{ht: 1, per: 2, to: 1'b0});
    for (int k = 0; k < 2; k++) begin
      pulse_start();
      wait_result(ok);
      checks++;
      if (!ok || exp_q.size() == 0) begin
        failures++; $display("FAIL b2b_wait_%0d got=no_result want=result_valid", k);
      end else begin
        e = exp_q.pop_front();
        if (high_time !== e.ht || period !== e.per) begin
          failures++; $display("FAIL b2b_result_%0d got=%0d/%0d want=%0d/%0d", k, high_time, period, e.ht, e.per);
        end
      end
      // start coinciding with the accept must not arm a new measurement
      start = 1'b1;
      accept();
      start = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_accept_start_%0d got=%b want=0", k, busy); end
    end
  endtask

`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
  task automatic test_watchdog();
    bit   ok;
    int   cyc;
    exp_t e;
    wave_en = 1'b0;
    repeat (60) @(negedge clk);
    exp_q.push_back('{ht: 0, per: 0, to: 1'b1});
    start = 1'b1;
    ok = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (result_valid === 1'b1) begin
        ok = 1'b1;
        cyc = i;
        break;
      end
    end
    checks++;
    if (!ok || cyc < TO || cyc > TO + 2) begin
      failures++; $display("FAIL wd_latency got=%0d want=%0d..%0d", cyc, TO, TO + 2);
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++; $display("FAIL wd_scoreboard got=empty want=entry");
    end else begin
      e = exp_q.pop_front();
      if (timeout !== e.to || period !== e.per || high_time !== e.ht) begin
        failures++; $display("FAIL wd_result got=%b/%0d/%0d want=%b/%0d/%0d",
                             timeout, period, high_time, e.to, e.per, e.ht);
      end
    end
    accept();
  endtask
`else
  task automatic test_no_watchdog();
    int bad;
    wave_en = 1'b0;
    repeat (60) @(negedge clk);
    pulse_start();
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || result_valid !== 1'b0 || timeout !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL nowd_wait got=%0d_bad_cycles want=0", bad); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL nowd_exit got=%b want=0", busy); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    start = 1'b0;
    result_ready = 1'b0;
    test_reset();
    test_basic();
    test_hold();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_period_meter.md
CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: width of the count and result fields.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000: watchdog limit in clk cycles; used only when the REQ-029 macro is defined.
REQ-003 SHALL have port clk, input, 1: the single clock; all flops on posedge clk.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port sig_in, input, 1: the slow square wave under measurement, e.g. a divided clock; asynchronous to clk.
REQ-006 SHALL have port start, input, 1: a one-cycle request to begin a measurement.
REQ-007 SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.
REQ-008 SHALL have port result_valid, output, 1: result available; held high until accepted.
REQ-009 SHALL have port result_ready, input, 1: consumer accept.
REQ-010 SHALL have port high_time, output, WIDTH: number of clk cycles from the sig_in rise to the sig_in fall.
REQ-011 SHALL have port period, output, WIDTH: number of clk cycles from one sig_in rise to the next sig_in rise.
REQ-012 SHALL have port timeout, output, 1: qualifies result_valid; high means the measurement was aborted.

Function
REQ-013 SHALL pass sig_in through a 2-flop synchronizer, followed by a registered copy used for edge detection.
  - rise = sync & ~prev; fall = ~sync & prev.
  - The fixed pipeline latency cancels in every reported difference.
REQ-014 SHALL implement FSM states IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW and DONE.
REQ-015 IDLE: on start, SHALL go to WAIT_RISE; start in any other state SHALL be ignored.
REQ-016 WAIT_RISE: on rise, SHALL load cnt=1 and go to MEAS_HIGH.
  - A fall seen in WAIT_RISE SHALL be ignored.
REQ-017 MEAS_HIGH: each cycle SHALL increment cnt.
  - On fall: capture high_time=cnt, then increment cnt and go to MEAS_LOW.
REQ-018 MEAS_LOW: each cycle SHALL increment cnt.
  - On rise: capture period=cnt, timeout=0, and go to DONE.
REQ-019 cnt SHALL saturate at 2^WIDTH-1 and never wrap.
REQ-020 DONE: result_valid SHALL be 1.
  - On result_ready=1, return to IDLE, with result_valid=0 on the next cycle.
  - high_time, period and timeout SHALL hold until the next capture.
REQ-021 start asserted in the same cycle as the result_ready accept in DONE SHALL be ignored; a new start is required from IDLE.
REQ-022 For a 50%-duty input toggling every m clk cycles, the block SHALL report high_time=m and period=2m exactly.
REQ-023 busy SHALL be combinationally decoded from the state register (state != IDLE).

Reset
REQ-024 On rst, the FSM SHALL enter IDLE immediately and asynchronously.
REQ-025 On rst, the following SHALL clear to 0: synchronizer flops, prev, cnt, high_time, period, timeout, result_valid and the watchdog.
REQ-026 rst asserted mid-measurement SHALL discard the partial result, with no result_valid pulse afterward.
REQ-027 Release of rst SHALL NOT create a spurious rise, because prev and sync both reset to 0.

Configuration
REQ-028 The optional feature SHALL be the watchdog, compiled in by macro CLOCK_PERIOD_METER_TIMEOUT_EN.
REQ-029 Defined: a watchdog counter SHALL clear on the entry to WAIT_RISE and increment in WAIT_RISE, MEAS_HIGH and MEAS_LOW.
  - At TIMEOUT_CYCLES it SHALL force DONE with timeout=1 and period=0.
  - high_time SHALL hold the captured value if the fall was seen, and 0 otherwise.
REQ-030 Undefined: no watchdog logic SHALL be present, timeout SHALL be tied to 0, and the FSM SHALL wait indefinitely.

Verification
REQ-031 Input toggling every 5 clk cycles, then start -> result_valid=1, high_time=5, period=10, timeout=0.
REQ-032 Input with 3 high and 7 low clk cycles -> high_time=3, period=10.
  - Then result_ready held 0 for 20 cycles -> result_valid and the data stay stable.
  - Then result_ready=1 -> IDLE next cycle.
REQ-033 start pulsed during MEAS_LOW -> ignored; the result equals that of the single-start case, and busy stays 1 throughout.
REQ-034 rst pulsed during MEAS_HIGH -> busy=0 and result_valid=0 immediately.
  - A fresh start after reset -> correct values with no stale data.
REQ-035 With the macro defined, TIMEOUT_CYCLES=100 and sig_in held at 0 -> after start, result_valid=1, timeout=1, period=0, high_time=0 within 100 to 102 cycles.
REQ-036 With the macro undefined, the same stimulus as REQ-035 -> busy stays 1 and result_valid=0 for 10000 cycles.
